// File: rtl/tt_neurocore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_neurocore_pkg
//  Description : Shared widths, mode encodings, reset constants and the
//                membrane saturation helper for the spiking neural core.
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_neurocore_pkg;

    localparam int N_NEURONS = 4;
    localparam int N_INPUTS  = 8;
    localparam int W_BITS    = 4;
    localparam int V_BITS    = 8;
    localparam int ACC_BITS  = 10;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_WR_W    = 2'b01;
    localparam logic [1:0] MODE_WR_TH   = 2'b10;
    localparam logic [1:0] MODE_WR_LEAK = 2'b11;

    localparam logic signed [V_BITS-1:0] TH_RESET   = 8'sd64;
    localparam logic [2:0]               LEAK_RESET = 3'd0;

    localparam logic signed [V_BITS-1:0]   V_MAX       = 8'h7F;
    localparam logic signed [V_BITS-1:0]   V_MIN       = 8'h80;
    localparam logic signed [ACC_BITS-1:0] ACC_SAT_MAX = 10'h07F;
    localparam logic signed [ACC_BITS-1:0] ACC_SAT_MIN = 10'h380;

    // Clamp a wide accumulator value into the signed membrane range.
    function automatic logic signed [V_BITS-1:0] saturate(input logic signed [ACC_BITS-1:0] x);
        if (x > ACC_SAT_MAX) begin
            return V_MAX;
        end else if (x < ACC_SAT_MIN) begin
            return V_MIN;
        end else begin
            return x[V_BITS-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron
//  Description : One leaky integrate-and-fire neuron. Holds its membrane
//                potential and a one-cycle spike bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron
    import tt_neurocore_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_INPUTS-1:0]              i_spikes,
    input  logic [N_INPUTS-1:0][W_BITS-1:0]  i_weights,
    input  logic signed [V_BITS-1:0]         i_threshold,
    input  logic [2:0]                       i_leak,
    input  logic                             i_run,
    input  logic                             i_clr_spike,
    input  logic                             i_clr_all,
    output logic signed [V_BITS-1:0]         o_v,
    output logic                             o_spike
);

    logic signed [V_BITS-1:0]   r_v;
    logic                       r_spike;

    logic signed [ACC_BITS-1:0] w_v_ext;
    logic signed [ACC_BITS-1:0] w_leaked;
    logic signed [ACC_BITS-1:0] w_sum;
    logic signed [ACC_BITS-1:0] w_th_ext;
    logic                       w_fire;

    // Leak the membrane, add the weights of active synapses, compare to threshold.
    always_comb begin
        w_v_ext  = {{(ACC_BITS-V_BITS){r_v[V_BITS-1]}}, r_v};
        // A shift of zero would cancel the membrane entirely, so L = 0 means no leak.
        w_leaked = (i_leak == 3'd0) ? w_v_ext : (w_v_ext - (w_v_ext >>> i_leak));
        w_sum    = w_leaked;
        for (int s = 0; s < N_INPUTS; s++) begin
            if (i_spikes[s]) begin
                w_sum = w_sum + {{(ACC_BITS-W_BITS){i_weights[s][W_BITS-1]}}, i_weights[s]};
            end
        end
        w_th_ext = {{(ACC_BITS-V_BITS){i_threshold[V_BITS-1]}}, i_threshold};
        w_fire   = (w_sum >= w_th_ext);
    end

    // Membrane and spike state: update in run, clear on configuration writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_spike <= 1'b0;
        end else if (i_run) begin
            r_spike <= w_fire;
            r_v     <= w_fire ? '0 : saturate(w_sum);
        end else if (i_clr_all) begin
            r_v     <= '0;
            r_spike <= 1'b0;
        end else if (i_clr_spike) begin
            r_spike <= 1'b0;
        end
    end

    assign o_v     = r_v;
    assign o_spike = r_spike;

endmodule
`default_nettype wire

// File: rtl/tt_um_neurocore.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_neurocore
//  Description : Single-layer spiking core: 8 input spike lines, 4 LIF
//                neurons, programmable 4x8 signed weights, shared threshold
//                and leak. Spikes and a membrane probe drive uo_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_neurocore
    import tt_neurocore_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [N_NEURONS-1:0][N_INPUTS-1:0][W_BITS-1:0] r_weights;
    logic signed [V_BITS-1:0]                       r_threshold;
    logic [2:0]                                     r_leak;

    logic [1:0]               w_mode;
    logic                     w_run;
    logic                     w_clr_spike;
    logic                     w_clr_all;
    logic signed [V_BITS-1:0] w_v [N_NEURONS];
    logic [N_NEURONS-1:0]     w_spikes;
    logic                     w_unused;

    assign w_mode      = uio_in[6:5];
    assign w_run       = ena && (w_mode == MODE_RUN);
    assign w_clr_spike = ena && ((w_mode == MODE_WR_W) || (w_mode == MODE_WR_TH));
    assign w_clr_all   = ena && (w_mode == MODE_WR_LEAK);
    assign w_unused    = uio_in[7];

    // Configuration registers written through the bidirectional pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weights   <= '0;
            r_threshold <= TH_RESET;
            r_leak      <= LEAK_RESET;
        end else if (ena) begin
            case (w_mode)
                MODE_WR_W:    r_weights[uio_in[4:3]][uio_in[2:0]] <= ui_in[W_BITS-1:0];
                MODE_WR_TH:   r_threshold <= ui_in;
                MODE_WR_LEAK: r_leak      <= ui_in[2:0];
                default:      ;
            endcase
        end
    end

    generate
        for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
            lif_neuron u_neuron (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_spikes    (ui_in),
                .i_weights   (r_weights[n]),
                .i_threshold (r_threshold),
                .i_leak      (r_leak),
                .i_run       (w_run),
                .i_clr_spike (w_clr_spike),
                .i_clr_all   (w_clr_all),
                .o_v         (w_v[n]),
                .o_spike     (w_spikes[n])
            );
        end
    endgenerate

    // Probe mux follows uio_in[1:0] combinationally in every mode.
    assign uo_out  = {w_v[uio_in[1:0]][V_BITS-1:V_BITS-4], w_spikes};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_neurocore.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_um_neurocore
//  Description : Scoreboard bench for the spiking neural core with a
//                behavioural reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_neurocore;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];

    // Reference model state, plain integers.
    int m_w [4][8];
    int m_th;
    int m_l;
    int m_v [4];
    bit m_spk [4];

    tt_um_neurocore dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            for (int s = 0; s < 8; s++) m_w[n][s] = 0;
            m_v[n]   = 0;
            m_spk[n] = 1'b0;
        end
        m_th = 64;
        m_l  = 0;
    endfunction

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_step(input bit en, input logic [7:0] ui, input logic [7:0] uio);
        int sum;
        int leaked;
        int wv;
        if (!en) return;
        case (uio[6:5])
            2'b00: begin
                for (int n = 0; n < 4; n++) begin
                    leaked = (m_l == 0) ? m_v[n] : m_v[n] - floor_div(m_v[n], 1 << m_l);
                    sum = leaked;
                    for (int s = 0; s < 8; s++) if (ui[s]) sum += m_w[n][s];
                    if (sum >= m_th) begin
                        m_spk[n] = 1'b1;
                        m_v[n]   = 0;
                    end else begin
                        m_spk[n] = 1'b0;
                        m_v[n]   = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
                    end
                end
            end
            2'b01: begin
                wv = int'(ui[3:0]);
                if (wv > 7) wv -= 16;
                m_w[uio[4:3]][uio[2:0]] = wv;
                for (int n = 0; n < 4; n++) m_spk[n] = 1'b0;
            end
            2'b10: begin
                m_th = int'(ui);
                if (m_th > 127) m_th -= 256;
                for (int n = 0; n < 4; n++) m_spk[n] = 1'b0;
            end
            default: begin
                m_l = int'(ui[2:0]);
                for (int n = 0; n < 4; n++) begin
                    m_v[n]   = 0;
                    m_spk[n] = 1'b0;
                end
            end
        endcase
    endfunction

    function automatic logic [7:0] model_out(input logic [1:0] probe);
        logic [7:0] vb;
        logic [3:0] sp;
        vb = 8'(m_v[probe]);
        for (int n = 0; n < 4; n++) sp[n] = m_spk[n];
        return {vb[7:4], sp};
    endfunction

    // One clocked step: drive at negedge, update model at posedge, queue expectation.
    task automatic cycle(input bit en, input logic [7:0] ui, input logic [7:0] uio);
        @(negedge clk);
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        @(posedge clk);
        model_step(en, ui, uio);
        exp_q.push_back({8'h00, 8'h00, model_out(uio[1:0])});
        #3;
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        logic [23:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {8'h00, uio_oe, uio_out, uo_out}, {8'h00, e});
            end
        end
    end

    initial begin
        logic [7:0] r_ui;
        logic [7:0] r_uio;
        int         sel;

        model_reset();

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ena    = 1'($urandom);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            #1;
            check("reset_out", {8'h00, uio_oe, uio_out, uo_out}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h00, 8'h00);
            check("post_reset_idle", {24'h0, uo_out}, 32'h00);
        end

        // Integrate and fire on neuron 0.
        cycle(1'b1, 8'h07, 8'h20);
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'h01, 8'h00);
        check("int_v63", {24'h0, uo_out}, 32'h30);
        cycle(1'b1, 8'h01, 8'h00);
        check("int_fire", {24'h0, uo_out}, 32'h01);
        cycle(1'b1, 8'h01, 8'h00);
        check("int_after_fire", {24'h0, uo_out}, 32'h00);

        // Saturation on neuron 1.
        for (int s = 0; s < 8; s++) cycle(1'b1, 8'h08, 8'h28 | 8'(s));
        cycle(1'b1, 8'hFF, 8'h01);
        check("sat_m64", {24'h0, uo_out}, 32'hC0);
        cycle(1'b1, 8'hFF, 8'h01);
        check("sat_m128", {24'h0, uo_out}, 32'h80);
        cycle(1'b1, 8'hFF, 8'h01);
        check("sat_hold", {24'h0, uo_out}, 32'h80);

        // Leak decay on neuron 2.
        cycle(1'b1, 8'h7F, 8'h40);
        cycle(1'b1, 8'h01, 8'h60);
        cycle(1'b1, 8'h07, 8'h30);
        cycle(1'b1, 8'h01, 8'h02);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h00, 8'h02);

        // ena hold and clear: build visible membrane, then freeze.
        cycle(1'b1, 8'h00, 8'h60);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hFF, 8'h00);
        check("ena_setup", {24'h0, uo_out}, 32'h20);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h01, 8'h00);
            check("ena_hold", {24'h0, uo_out}, 32'h20);
        end
        cycle(1'b1, 8'h00, 8'h60);
        check("leak_clear", {24'h0, uo_out}, 32'h00);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_ui  = 8'($urandom);
            r_uio = 8'($urandom);
            sel   = $urandom_range(0, 19);
            if (sel < 15)      r_uio[6:5] = 2'b00;
            else if (sel < 18) r_uio[6:5] = 2'b01;
            else if (sel < 19) r_uio[6:5] = 2'b10;
            else               r_uio[6:5] = 2'b11;
            cycle($urandom_range(0, 9) != 0, r_ui, r_uio);
        end

        // Negative threshold: everything fires at rest, then reset mid-cycle.
        cycle(1'b1, 8'h00, 8'h60);
        cycle(1'b1, 8'h80, 8'h40);
        cycle(1'b1, 8'h00, 8'h00);
        check("neg_th_fire", {24'h0, uo_out}, 32'h0F);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_out", {8'h00, uio_oe, uio_out, uo_out}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'h01, 8'h00);
            check("midreset_nospike", {31'h0, uo_out[0]}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_neurocore.md
Name: tt_um_neurocore

Overview:
- Single-layer spiking neural core for a TinyTapeout tile: 8 binary input spike lines feed 4 leaky integrate-and-fire (LIF) neurons through a 4x8 matrix of programmable signed weights.
- Weights, the shared firing threshold and the shared leak are written through the bidirectional pins, which are used as inputs only.
- Output spikes and a membrane probe appear on the dedicated outputs.
- Top-level user module of the chip.

Parameters:
- N_NEURONS, 4, number of neurons (fixed by pinout)
- N_INPUTS, 8, number of input spike lines (fixed by pinout)
- W_BITS, 4, signed weight width
- V_BITS, 8, signed membrane width

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when 0, all state holds
- ui_in  input  8  run mode: input spikes, bit i = synapse i; config modes: write data
- uo_out  output  8  [3:0] registered spike of neurons 3..0; [7:4] = membrane[7:4] of the neuron selected by uio_in[1:0]
- uio_in  input  8  [6:5] mode; [4:0] weight address (config) or [1:0] probe select (run); [7] reserved
- uio_out  output  8  constant 0
- uio_oe  output  8  constant 0 (all bidirectional pins are inputs)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - weights = 0
  - threshold = +64
  - leak L = 0 (no leak)
  - all membranes V = 0
  - spike register = 0
  - uo_out = 0, uio_out = 0, uio_oe = 0
- ena = 0: no state changes (run updates and config writes are both ignored). Outputs keep reflecting held state.
- Modes, selected by uio_in[6:5] and applied on the clock edge when ena = 1:
  - 00 RUN: one neuron update per cycle.
  - 01 WRITE WEIGHT: W[n][s] <= ui_in[3:0]. n = uio_in[4:3], s = uio_in[2:0]. Membranes hold; spikes clear to 0.
  - 10 WRITE THRESHOLD: threshold <= ui_in, signed 8-bit. Membranes hold; spikes clear.
  - 11 WRITE LEAK: L <= ui_in[2:0]. All membranes and spikes clear to 0.
- RUN update, per neuron n, in signed arithmetic of at least 10 bits:
  - leaked = (L == 0) ? V : V - (V >>> L), arithmetic shift.
  - sum = leaked + sum over s of (ui_in[s] ? W[n][s] : 0). Range is [-192, 183].
  - If sum >= threshold (signed compare): spike[n] <= 1 and V <= 0.
  - Otherwise: spike[n] <= 0 and V <= sum saturated to [-128, 127].
- Latency: input sampled at edge k is reflected in spike and membrane state right after edge k. Each spike lasts exactly one cycle per firing event. A neuron can fire on consecutive cycles.
- Threshold <= 0 is legal; the neuron then fires whenever sum >= threshold, including at rest.
- uo_out[7:4] is a combinational mux driven from registered V. The probe follows uio_in[1:0] immediately, in any mode.
- Asserting rst_n low mid-operation immediately clears all state, including configuration.

Decomposition:
- Package tt_neurocore_pkg:
  - widths: W_BITS, V_BITS, ACC_BITS = 10
  - mode encodings: MODE_RUN, MODE_WR_W, MODE_WR_TH, MODE_WR_LEAK
  - reset constants: TH_RESET = 64, LEAK_RESET = 0
  - saturate function
- One sub-module: lif_neuron, instantiated 4 times.
  - Inputs: 8 spikes, 8 weights, threshold, L, run/clear controls.
  - Holds V and its spike bit.
- The top module holds the weight/threshold/leak registers, mode decode and output muxing.

Test Plan:
- Reset: assert rst_n = 0 with random inputs -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0x00. After release in RUN with ui_in = 0x00 -> uo_out stays 0x00.
- Integrate and fire:
  - Setup: write W[0][0] = 7 (mode 01, addr 0, ui_in = 0x07); default threshold 64; L = 0.
  - Stimulus: RUN with ui_in = 0x01, uio_in[1:0] = 0.
  - After 9 updates: V = 63, uo_out = 0x30.
  - 10th update: sum = 70 -> uo_out[0] = 1 for one cycle with V = 0 (uo_out = 0x01).
  - Next cycle: V = 7, uo_out = 0x00.
- Saturation:
  - Setup: write all W[1][s] = -8 (0x8).
  - Stimulus: RUN with ui_in = 0xFF, probe = 1.
  - V goes -64, then -128, and stays at -128 -> uo_out[7:4] = 0x8, no spike.
- Leak decay:
  - Setup: threshold = 127, mode 11 with ui_in = 1 (L = 1), W[2][0] = 7.
  - Stimulus: one RUN cycle with ui_in = 0x01, then ui_in = 0x00.
  - V sequence: 7, 4, 2, 1, 1, 1 (stays 1).
- ena and clear:
  - With V[0] != 0, ena = 0 for 5 cycles with ui_in = 0x01 -> V and uo_out unchanged.
  - Mode 11 with ena = 1 -> all V = 0, spikes = 0.
- Mid-run reset: pulse rst_n low between edges -> uo_out = 0 immediately. After release, the W[0][0] stimulus produces no spike, because the weights were cleared.
